// File: rtl/register_file_writeback_pkg.sv
// Shared types for the operand/writeback stage: data width, flags layout,
// register count and register address type.
package register_file_writeback_pkg;

  localparam int DataWidth    = 8;
  localparam int NumRegisters = 16;
  localparam int RegAddrWidth = $clog2(NumRegisters);

  typedef logic [DataWidth-1:0]    tData;
  typedef logic [RegAddrWidth-1:0] tRegAddr;

  typedef struct packed {
    logic Overflow;
    logic Negative;
    logic Zero;
    logic Carry;
  } sFlags;

  function automatic logic is_zero_reg(tRegAddr a);
    return a == '0;
  endfunction

endpackage

// File: rtl/register_file_writeback_if.sv
// Operand/writeback bus between the ALU side (master) and the register
// file stage (slave): read addresses/data, result write, flags, stall.
interface register_file_writeback_if;
  import register_file_writeback_pkg::*;

  tRegAddr SrcAddr;
  tRegAddr DestAddr;
  tData    SrcData;
  tData    DestData;
  logic    WbValid;
  tData    WbData;
  logic    WbFlagsEn;
  sFlags   WbFlags;
  logic    Stall;
  sFlags   Flags;
  logic    PendValid;

  modport master (
    output SrcAddr, DestAddr, WbValid, WbData,
    output WbFlagsEn, WbFlags, Stall,
    input  SrcData, DestData, Flags, PendValid
  );

  modport slave (
    input  SrcAddr, DestAddr, WbValid, WbData,
    input  WbFlagsEn, WbFlags, Stall,
    output SrcData, DestData, Flags, PendValid
  );

endinterface

// File: rtl/register_file_writeback_forward_mux.sv
// One read port: priority select zero-reg / incoming result / pending
// write / array. Ports: addr in, forwarding sources in, data out.
module register_forward_mux
  import register_file_writeback_pkg::*;
#(
  parameter int DataWidth    = register_file_writeback_pkg::DataWidth,
  parameter int RegAddrWidth = register_file_writeback_pkg::RegAddrWidth
) (
  input  logic [RegAddrWidth-1:0] addr,
  input  logic                    wb_hit,
  input  logic [RegAddrWidth-1:0] wb_addr,
  input  logic [DataWidth-1:0]    wb_data,
  input  logic                    pend_valid,
  input  logic [RegAddrWidth-1:0] pend_addr,
  input  logic [DataWidth-1:0]    pend_data,
  input  logic [DataWidth-1:0]    arr_data,
  output logic [DataWidth-1:0]    data
);

  always_comb begin
    data = arr_data;
    if (addr == '0)
      data = '0;
    else if (wb_hit && addr == wb_addr)
      data = wb_data;
    else if (pend_valid && addr == pend_addr)
      data = pend_data;
  end

endmodule

// File: rtl/register_file_writeback.sv
// Operand/writeback stage: two forwarded read ports, one-deep write
// pipeline into the register array, architectural flags register.
module register_file_writeback
  import register_file_writeback_pkg::*;
#(
  parameter int DataWidth    = register_file_writeback_pkg::DataWidth,
  parameter int NumRegisters = register_file_writeback_pkg::NumRegisters,
  parameter int RegAddrWidth = $clog2(NumRegisters)
) (
  input logic Clock,
  input logic Reset,
  register_file_writeback_if.slave bus
);

  logic [DataWidth-1:0]    regs [NumRegisters];
  logic                    pend_valid;
  logic [RegAddrWidth-1:0] pend_addr;
  logic [DataWidth-1:0]    pend_data;
  sFlags                   flags_q;
  logic                    wb_hit;

  assign wb_hit = bus.WbValid && !bus.Stall;

  // Commit of the old pending entry and load of the new one share an
  // edge; the array write uses the pre-edge pending values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NumRegisters; i++)
        regs[i] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      flags_q    <= '0;
    end else if (!bus.Stall) begin
      if (pend_valid && pend_addr != '0)
        regs[pend_addr] <= pend_data;
      pend_valid <= bus.WbValid;
      pend_addr  <= bus.DestAddr;
      pend_data  <= bus.WbData;
      if (bus.WbFlagsEn)
        flags_q <= bus.WbFlags;
    end
  end

  register_forward_mux #(
    .DataWidth    (DataWidth),
    .RegAddrWidth (RegAddrWidth)
  ) u_src_mux (
    .addr       (bus.SrcAddr),
    .wb_hit     (wb_hit),
    .wb_addr    (bus.DestAddr),
    .wb_data    (bus.WbData),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .arr_data   (regs[bus.SrcAddr]),
    .data       (bus.SrcData)
  );

  register_forward_mux #(
    .DataWidth    (DataWidth),
    .RegAddrWidth (RegAddrWidth)
  ) u_dest_mux (
    .addr       (bus.DestAddr),
    .wb_hit     (wb_hit),
    .wb_addr    (bus.DestAddr),
    .wb_data    (bus.WbData),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .arr_data   (regs[bus.DestAddr]),
    .data       (bus.DestData)
  );

  assign bus.Flags     = flags_q;
  assign bus.PendValid = pend_valid;

endmodule

// File: doc/register_file_writeback.md
Name: register_file_writeback

Overview:
- Operand and writeback stage around the ALU.
- Supplies InSrc/InDest values to the ALU from a general-purpose register array, and holds the architectural flags register that feeds InFlags.
- Captures the ALU result (OutDest/OutFlags) through a one-deep writeback pipeline register and commits it to the array on the following edge.
- Forwarding guarantees back-to-back dependent instructions read the newest value.

Parameters:
- DataWidth, 8, register and data bus width; must equal the package DataWidth.
- NumRegisters, 16, number of general registers; power of two, at least 2.
- RegAddrWidth, $clog2(NumRegisters), register address width.

Ports:
- Clock  input  1  single system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SrcAddr  input  RegAddrWidth  source register select.
- DestAddr  input  RegAddrWidth  destination register select (read and write target).
- SrcData  output  DataWidth  forwarded value of register SrcAddr; drives ALU InSrc.
- DestData  output  DataWidth  forwarded value of register DestAddr; drives ALU InDest.
- WbValid  input  1  ALU result valid this cycle; write OutDest to DestAddr.
- WbData  input  DataWidth  ALU OutDest.
- WbFlagsEn  input  1  update flags from WbFlags this cycle.
- WbFlags  input  sFlags  ALU OutFlags.
- Stall  input  1  freeze writeback stage; incoming WbValid/WbFlagsEn ignored.
- Flags  output  sFlags  architectural flags; drives ALU InFlags.
- PendValid  output  1  writeback stage holds an uncommitted write (debug/verification).

Behaviour:
- Reset (asynchronous, immediate):
  - All array entries cleared to 0.
  - Flags cleared to 0 (all fields).
  - Pending stage invalidated: PendValid=0, PendAddr=0, PendData=0.
  - Reset asserted mid-operation discards any pending write; it is never committed.
- Register 0 is hardwired zero:
  - Reads of address 0 return 0 regardless of forwarding.
  - Writes to address 0 are accepted into the pending stage but never change the array.
  - Writes to address 0 never forward a nonzero value.
- Write path, rising edge with Stall=0:
  - If PendValid and PendAddr != 0: array[PendAddr] <= PendData.
  - Then pending stage loads PendValid<=WbValid, PendAddr<=DestAddr, PendData<=WbData.
  - Write latency: input cycle N -> pending at edge N -> array at edge N+1.
- Write path, Stall=1: pending stage and array hold; WbValid, WbData, WbFlagsEn and WbFlags are ignored and dropped.
- Flags path:
  - Flags <= WbFlags on the edge where WbFlagsEn=1 and Stall=0; otherwise Flags hold.
  - Flags are not pipelined: they are visible one cycle after WbFlagsEn.
- Read path (combinational, zero latency), per port with address A; first match wins:
  1. A==0 -> 0.
  2. WbValid && !Stall && A==DestAddr -> WbData. Forwarding from the incoming result: DestData equals WbData when asserted.
  3. PendValid && A==PendAddr -> PendData.
  4. Otherwise array[A].
- Both read ports may select the same register; both see identical values.
- Consecutive writes to the same address: newest wins. Pending overwrite and commit in the same edge are correct by the ordering above.
- No combinational path from Reset to the read data other than through cleared state.

Decomposition:
- InstructionSetPkg gains:
  - NumRegisters and RegAddrWidth constants.
  - typedef logic [RegAddrWidth-1:0] tRegAddr.
- sFlags and DataWidth are reused from the package unchanged.
- One natural sub-module: register_forward_mux. Combinational 3-way priority select with the zero-register rule; instantiated twice, once per read port.

Test Plan:
- Reset check: assert Reset mid-run after writing R3=8'h5A. Then SrcAddr=3 -> SrcData=0, Flags=0, PendValid=0, immediately without waiting for a clock.
- Write/commit latency: cycle 0 WbValid=1, DestAddr=4, WbData=8'hA5. Then:
  - Cycle 1: PendValid=1, SrcAddr=4 -> 8'hA5 via pending.
  - Cycle 2: PendValid=0, SrcAddr=4 -> 8'hA5 via array.
- Forward priority: pending R2=8'h11 while incoming WbValid writes R2=8'h22 -> SrcData=DestData=8'h22. One cycle later R2 reads 8'h22; array never retains 8'h11 after the next commit.
- Zero register: WbValid=1, DestAddr=0, WbData=8'hFF -> SrcAddr=0 reads 0 in the same cycle, the next cycle and all later cycles.
- Stall: pending R5=8'h33, Stall=1 for 3 cycles with WbValid=1, DestAddr=6, WbData=8'h44, WbFlagsEn=1, Carry=1. Then:
  - R5 still pending (PendValid=1).
  - R6 unchanged; Flags.Carry unchanged.
  - After Stall=0, R5 commits 8'h33 on the next edge.
- Flags update: WbFlagsEn=1 with WbFlags.Carry=1, then WbFlagsEn=0 with Carry=0 -> Flags.Carry=1 after the first edge and stays 1.
